// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse macro emulator.
package efuse_pkg;

    localparam int N_BITS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PGM,
        ST_READ,
        ST_ABORT
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ONEHOT   = 3'd1;
    localparam logic [2:0] ERR_WERP_CHG = 3'd2;
    localparam logic [2:0] ERR_MODE     = 3'd3;
    localparam logic [2:0] ERR_SHORT    = 3'd4;
    localparam logic [2:0] ERR_RE_PGM   = 3'd5;

endpackage

// File: rtl/efuse_onehot_chk.sv
// One-hot check and index encoder for the WERP word-line select.
module efuse_onehot_chk #(
    parameter int N_BITS = 64,
    parameter int IW     = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
    input  logic [N_BITS-1:0] i_werp,
    output logic              o_valid,
    output logic [IW-1:0]     o_idx
);

    logic seen;
    logic multi;

    // OR-ing indices is only meaningful when exactly one bit is set, which o_valid reports.
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        o_idx = '0;
        for (int i = 0; i < N_BITS; i++) begin
            if (i_werp[i]) begin
                if (seen) multi = 1'b1;
                seen  = 1'b1;
                o_idx = o_idx | IW'(i);
            end
        end
        o_valid = seen & ~multi;
    end

endmodule

// File: rtl/efuse_emu.sv
// Register-based responder model of the 64-bit OTP eFuse macro with protocol checking.
// Optional margin model (weak fuses, WSEL latch, RD margin read) enabled by EFUSE_EMU_MARGIN_EN.
module efuse_emu
    import efuse_pkg::*;
#(
    parameter int                N_BITS      = N_BITS_DEF,
    parameter int                PGM_MIN_CYC = 16,
    parameter logic [3:0]        WSEL_MIN    = 4'd4,
    parameter logic [N_BITS-1:0] INIT_VAL    = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_resetb,
    input  logic [N_BITS-1:0] i_werp,
    input  logic              i_access,
    input  logic              i_wren,
    input  logic              i_peb,
    input  logic              i_re,
    input  logic [3:0]        i_wsel,
    input  logic [1:0]        i_rd,
    output logic              o_output,
    output logic              o_err,
    output logic [2:0]        o_err_code,
    output logic [N_BITS-1:0] o_fuse
);

    localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int CW = $clog2(PGM_MIN_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PGM_MIN_CYC);

    state_e            state_q, state_d;
    logic              access_q;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N_BITS-1:0] werp_q, werp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_BITS-1:0] fuse_q, fuse_d;
    logic              out_q, out_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;
    logic [2:0]        raise;

    logic              werp_ok;
    logic [IW-1:0]     werp_idx;
    logic              rise;
    logic              werp_chg;
    logic              eff_bit;

    efuse_onehot_chk #(.N_BITS(N_BITS), .IW(IW)) u_onehot (
        .i_werp (i_werp),
        .o_valid(werp_ok),
        .o_idx  (werp_idx)
    );

    assign rise     = i_access & ~access_q;
    assign werp_chg = (i_werp != werp_q);

`ifdef EFUSE_EMU_MARGIN_EN
    logic [N_BITS-1:0] weak_q, weak_d;
    logic [3:0]        wsel_q, wsel_d;
    logic              new_weak;

    assign new_weak = (wsel_q < WSEL_MIN);
    assign eff_bit  = fuse_q[idx_q] & ~(weak_q[idx_q] & (i_rd != 2'd0));
`else
    logic unused_margin;
    assign unused_margin = ^{i_wsel, i_rd};
    assign eff_bit       = fuse_q[idx_q];
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        werp_d  = werp_q;
        cnt_d   = cnt_q;
        fuse_d  = fuse_q;
        out_d   = out_q;
        err_d   = err_q;
        code_d  = code_q;
        raise   = ERR_NONE;
`ifdef EFUSE_EMU_MARGIN_EN
        weak_d  = weak_q;
        wsel_d  = wsel_q;
`endif
        if (!i_resetb) begin
            // Functional reset: array and error capture survive, in-flight program is dropped.
            state_d = ST_IDLE;
            out_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        werp_d = i_werp;
                        idx_d  = werp_idx;
`ifdef EFUSE_EMU_MARGIN_EN
                        wsel_d = i_wsel;
`endif
                        if (!werp_ok) begin
                            raise   = ERR_ONEHOT;
                            state_d = ST_ABORT;
                        end else if (i_wren && !i_peb) begin
                            state_d = ST_PGM;
                            cnt_d   = '0;
                        end else if (!i_wren && i_peb) begin
                            state_d = ST_READ;
                        end else begin
                            raise   = ERR_MODE;
                            state_d = ST_ABORT;
                        end
                    end
                end
                ST_PGM: begin
                    if (werp_chg) begin
                        raise   = ERR_WERP_CHG;
                        state_d = ST_ABORT;
                    end else if (i_re) begin
                        raise   = ERR_RE_PGM;
                        state_d = ST_ABORT;
                    end else if (!i_access) begin
                        state_d = ST_IDLE;
                        if (cnt_q >= CNT_MAX) begin
                            fuse_d[idx_q] = 1'b1;
`ifdef EFUSE_EMU_MARGIN_EN
                            // A reblow can only strengthen an already-blown fuse.
                            weak_d[idx_q] = fuse_q[idx_q] ? (weak_q[idx_q] & new_weak) : new_weak;
`endif
                        end else begin
                            raise = ERR_SHORT;
                        end
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_READ: begin
                    if (werp_chg) begin
                        raise   = ERR_WERP_CHG;
                        state_d = ST_ABORT;
                    end else begin
                        if (i_re) out_d = eff_bit;
                        if (!i_access) state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (!i_access) state_d = ST_IDLE;
                    else if (werp_chg) raise = ERR_WERP_CHG;
                end
            endcase
            if (raise != ERR_NONE) begin
                err_d = 1'b1;
                if (!err_q) code_d = raise;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            access_q <= 1'b0;
            idx_q    <= '0;
            werp_q   <= '0;
            cnt_q    <= '0;
            fuse_q   <= INIT_VAL;
            out_q    <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            access_q <= i_access;
            idx_q    <= idx_d;
            werp_q   <= werp_d;
            cnt_q    <= cnt_d;
            fuse_q   <= fuse_d;
            out_q    <= out_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

`ifdef EFUSE_EMU_MARGIN_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            weak_q <= '0;
            wsel_q <= '0;
        end else begin
            weak_q <= weak_d;
            wsel_q <= wsel_d;
        end
    end
`endif

    assign o_output   = out_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;
    assign o_fuse     = fuse_q;

endmodule

// File: tb/tb_efuse_emu.sv
// Directed self-checking bench for efuse_emu; margin checks follow EFUSE_EMU_MARGIN_EN.
module tb_efuse_emu;

    localparam logic [63:0] INIT = 64'h8000_0000_0000_0001;

    logic        clk = 1'b0;
    logic        rst, resetb, access, wren, peb, re;
    logic [63:0] werp;
    logic [3:0]  wsel;
    logic [1:0]  rd;
    logic        out_bit, err;
    logic [2:0]  err_code;
    logic [63:0] fuse;

    int n_tests = 0;
    int n_fail  = 0;

    efuse_emu #(.N_BITS(64), .PGM_MIN_CYC(16), .WSEL_MIN(4'd4), .INIT_VAL(INIT)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_resetb  (resetb),
        .i_werp    (werp),
        .i_access  (access),
        .i_wren    (wren),
        .i_peb     (peb),
        .i_re      (re),
        .i_wsel    (wsel),
        .i_rd      (rd),
        .o_output  (out_bit),
        .o_err     (err),
        .o_err_code(err_code),
        .o_fuse    (fuse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ACCESS is high for 'hold' sampled edges, the first being the rising edge.
    task automatic program_bit(input int idx, input int hold, input logic [3:0] ws);
        werp   = 64'd1 << idx;
        wren   = 1'b1;
        peb    = 1'b0;
        wsel   = ws;
        access = 1'b1;
        repeat (hold) tick();
        access = 1'b0;
        tick();
        wren = 1'b0;
        peb  = 1'b1;
    endtask

    task automatic read_bit(input int idx, input logic [1:0] margin, output logic v);
        werp   = 64'd1 << idx;
        wren   = 1'b0;
        peb    = 1'b1;
        access = 1'b1;
        tick();
        re = 1'b1;
        rd = margin;
        tick();
        re = 1'b0;
        tick();
        access = 1'b0;
        tick();
        v = out_bit;
    endtask

    logic        v;
    logic [63:0] word;

    initial begin
        rst = 1'b1; resetb = 1'b1; access = 1'b0; wren = 1'b0; peb = 1'b1;
        re = 1'b0; werp = '0; wsel = 4'd8; rd = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out", {63'd0, out_bit}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_code", {61'd0, err_code}, 64'd0);
        check("rst_fuse", fuse, INIT);

        // Full-length blow then nominal read.
        program_bit(5, 17, 4'd8);
        check("blow5_fuse", fuse, INIT | 64'h20);
        read_bit(5, 2'd0, v);
        check("read5", {63'd0, v}, 64'd1);
        check("blow5_err", {63'd0, err}, 64'd0);

        // Non-one-hot WERP at rise: abort, no read performed, output holds.
        werp = 64'h3; wren = 1'b0; peb = 1'b1; access = 1'b1;
        tick();
        re = 1'b1;
        tick();
        re = 1'b0; access = 1'b0;
        tick();
        check("onehot_code", {61'd0, err_code}, 64'd1);
        check("onehot_err", {63'd0, err}, 64'd1);
        check("onehot_out", {63'd0, out_bit}, 64'd1);

        do_rst();
        check("rst2_err", {63'd0, err}, 64'd0);
        check("rst2_fuse", fuse, INIT);

        // Short pulses: 10 edges and the 16-edge boundary both fail; 17 blows.
        program_bit(9, 10, 4'd8);
        check("short_err", {63'd0, err}, 64'd1);
        check("short_code", {61'd0, err_code}, 64'd4);
        check("short_fuse9", {63'd0, fuse[9]}, 64'd0);
        program_bit(7, 16, 4'd8);
        check("bound16_fuse7", {63'd0, fuse[7]}, 64'd0);
        program_bit(7, 17, 4'd8);
        check("bound17_fuse7", {63'd0, fuse[7]}, 64'd1);
        check("first_code", {61'd0, err_code}, 64'd4);

        // Weak blow, margin read, strong reblow.
        program_bit(2, 17, 4'd2);
        read_bit(2, 2'd0, v);
        check("weak_rd0", {63'd0, v}, 64'd1);
        read_bit(2, 2'd1, v);
`ifdef EFUSE_EMU_MARGIN_EN
        check("weak_rd1", {63'd0, v}, 64'd0);
`else
        check("weak_rd1", {63'd0, v}, 64'd1);
`endif
        program_bit(2, 17, 4'd8);
        read_bit(2, 2'd1, v);
        check("strong_rd1", {63'd0, v}, 64'd1);

        // RESETB mid-program: output cleared, no blow, then full array read.
        do_rst();
        read_bit(0, 2'd0, v);
        check("init_bit0", {63'd0, v}, 64'd1);
        werp = 64'd1 << 3; wren = 1'b1; peb = 1'b0; access = 1'b1;
        repeat (8) tick();
        resetb = 1'b0;
        tick();
        check("resetb_out", {63'd0, out_bit}, 64'd0);
        access = 1'b0; resetb = 1'b1; wren = 1'b0; peb = 1'b1;
        repeat (20) tick();
        check("resetb_fuse", fuse, INIT);
        word = '0;
        for (int i = 0; i < 64; i++) begin
            read_bit(i, 2'd0, v);
            word[i] = v;
        end
        check("full_read", word, INIT);
        check("full_read_err", {63'd0, err}, 64'd0);

        // WERP change during read access.
        werp = 64'd1 << 4; wren = 1'b0; peb = 1'b1; access = 1'b1;
        tick();
        werp = 64'd1 << 6;
        tick();
        access = 1'b0;
        tick();
        check("werp_chg_code", {61'd0, err_code}, 64'd2);
        do_rst();
        check("rst3_err", {63'd0, err}, 64'd0);
        check("rst3_fuse", fuse, INIT);

        // RE during program: abort without blow.
        werp = 64'd1 << 1; wren = 1'b1; peb = 1'b0; access = 1'b1;
        repeat (17) tick();
        re = 1'b1;
        tick();
        re = 1'b0; access = 1'b0; wren = 1'b0; peb = 1'b1;
        tick();
        check("re_pgm_code", {61'd0, err_code}, 64'd5);
        check("re_pgm_fuse1", {63'd0, fuse[1]}, 64'd0);

        // Illegal wren/peb combination.
        do_rst();
        werp = 64'd1 << 8; wren = 1'b1; peb = 1'b1; access = 1'b1;
        tick();
        access = 1'b0; wren = 1'b0;
        tick();
        check("mode_code", {61'd0, err_code}, 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
